// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the receive-buffer entry layout.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage is intentionally not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer downstream of the UART receiver, with
// occupancy/full/empty status and a sticky overflow flag for dropped bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_err,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [PW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          overflow_r;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [DATA_W:0] rd_entry_s;

  // Status comes straight from the registered pointers; the extra MSB separates full from empty.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                   (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);

  // Handshake decode: a pop in the same cycle frees the slot a full-FIFO write needs.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (!empty_s && rd_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (wr_en && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (wr_en && full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Pointer and sticky-overflow state; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_mem (
    .clk   (clk),
    .we    (push_s && !reset),
    .waddr (wr_ptr_r[PW-2:0]),
    .wdata ({wr_err, wr_data}),
    .raddr (rd_ptr_r[PW-2:0]),
    .rdata (rd_entry_s)
  );

  assign rd_valid = !empty_s;
  assign rd_data  = rd_entry_s[DATA_W-1:0];
  assign rd_err   = rd_entry_s[DATA_W];
  assign count    = wr_ptr_r - rd_ptr_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = overflow_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard-based bench for uart_rx_fifo: per-scenario tasks compare DUT outputs against a queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_err = 1'b0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int checks = 0;
  int failures = 0;
  uart_rx_entry_t sb[$];
  logic ovf_m = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Drives one clock cycle of stimulus and advances the model; outputs are sampled 1ns after the edge.
  task automatic drive(input logic we, input logic [7:0] d, input logic e,
                       input logic rr, input logic clr);
    logic pop_m, push_m, full_m;
    uart_rx_entry_t tmp;
    wr_en = we; wr_data = d; wr_err = e; rd_ready = rr; clr_overflow = clr;
    pop_m  = (sb.size() != 0) && rr;
    full_m = (sb.size() == DEPTH);
    push_m = we && (!full_m || pop_m);
    @(posedge clk); #1;
    if (pop_m) tmp = sb.pop_front();
    if (push_m) begin
      tmp.err = e; tmp.data = d;
      sb.push_back(tmp);
    end
    if (we && full_m && !pop_m) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    wr_en = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rd_data); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", rd_err); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
    // Empty with rd_ready must not move the read pointer.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL empty_pop count=%0d empty=%b exp=0/1", count, empty); end
  endtask

  task automatic test_fill_drain();
    fill_seq();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin failures++; $display("FAIL drain_data[%0d] got=%h valid=%b exp=%h", i, rd_data, rd_valid, 8'(i)); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    fill_seq();
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== ovf_m || overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, rd_data, 8'(i)); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_final_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pass();
    fill_seq();
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pass_no_ovf got=%b exp=0", overflow); end
    checks++; if (count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL pass_count got=%0d full=%b exp=16/1", count, full); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== sb[0].data) begin failures++; $display("FAIL pass_drain[%0d] got=%h exp=%h", i, rd_data, sb[0].data); end
      if (i == DEPTH - 1) begin
        checks++; if (rd_data !== 8'h55) begin failures++; $display("FAIL pass_last got=%h exp=55", rd_data); end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_err();
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_err !== 1'b1 || rd_data !== 8'h3C) begin failures++; $display("FAIL err_first got=%b/%h exp=1/3c", rd_err, rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (rd_err !== 1'b0 || rd_data !== 8'h3D) begin failures++; $display("FAIL err_second got=%b/%h exp=0/3d", rd_err, rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 40; c++) begin
      logic we, rr, e;
      logic [7:0] d;
      we = 1'($urandom_range(0, 99) < 60);
      rr = 1'($urandom_range(0, 99) < 45);
      e  = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      drive(we, d, e, rr, 1'b0);
      checks++; if (count !== 5'(sb.size()) || rd_valid !== (sb.size() != 0) || overflow !== ovf_m)
        begin failures++; $display("FAIL rand_status[%0d] count=%0d valid=%b ovf=%b exp=%0d/%b/%b", c, count, rd_valid, overflow, sb.size(), sb.size() != 0, ovf_m); end
      if (sb.size() != 0) begin
        checks++; if (rd_data !== sb[0].data || rd_err !== sb[0].err)
          begin failures++; $display("FAIL rand_head[%0d] got=%b/%h exp=%b/%h", c, rd_err, rd_data, sb[0].err, sb[0].data); end
      end
    end
    while (sb.size() != 0) begin
      checks++; if (rd_data !== sb[0].data || rd_err !== sb[0].err)
        begin failures++; $display("FAIL rand_drain got=%b/%h exp=%b/%h", rd_err, rd_data, sb[0].err, sb[0].data); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL mid_count_before got=%0d exp=5", count); end
    #1 reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0)
      begin failures++; $display("FAIL mid_reset count=%0d empty=%b valid=%b exp=0/1/0", count, empty, rd_valid); end
    sb.delete();
    ovf_m = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h7E || rd_err !== 1'b1 || count !== 5'd1)
      begin failures++; $display("FAIL mid_after got=%b/%h/%b/%0d exp=1/7e/1/1", rd_valid, rd_data, rd_err, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_pass();
    test_err();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receiver. Captures each received byte with its framing-error flag on the receiver's one-cycle done strobe and stores it in a first-word-fall-through FIFO. Software or a downstream consumer drains it through a valid/ready read port. Full, empty, occupancy and a sticky overflow flag are exported for the status register block.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- DATA_W, 8, byte width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  one-cycle strobe, byte available (driven by receiver done pulse)
- wr_data  in  DATA_W  received byte, valid when wr_en=1
- wr_err  in  1  framing-error flag for the byte, valid when wr_en=1
- rd_valid  out  1  head entry available (= !empty)
- rd_ready  in  1  consumer accepts head entry
- rd_data  out  DATA_W  head entry byte
- rd_err  out  1  head entry error flag
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a byte was dropped
- clr_overflow  in  1  one-cycle clear of overflow

## Operation
- Entry = {wr_err, wr_data}, DATA_W+1 bits.
- pop = rd_valid && rd_ready. push = wr_en && (!full || pop).
- Push writes entry at wr_ptr, wr_ptr increments. Pop increments rd_ptr. rd_data/rd_err always show the entry at rd_ptr. Contents are don't-care when empty.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full/empty come from pointer compare: MSBs differ with low bits equal means full; pointers equal means empty. count = wr_ptr − rd_ptr, modulo 2^(width).
- Boundary cases:
  - Full with wr_en and pop in the same cycle: both occur, count stays DEPTH, no overflow.
  - Full with wr_en and no pop: byte dropped, overflow set next cycle, FIFO contents unchanged.
  - Empty with rd_ready: no pop, pointers unchanged.
  - Empty with wr_en and rd_ready: push only. The entry becomes visible next cycle.
  - Push and pop when neither full nor empty: count unchanged.
- overflow:
  - Set by a drop event.
  - Cleared by clr_overflow.
  - If both occur in the same cycle, set wins.
- wr_err is stored as-is. The FIFO never discards error bytes.

## Timing
- All state is registered on posedge clk. Reset is asynchronous.
- Reset values: pointers 0, count 0, empty 1, full 0, rd_valid 0, overflow 0. rd_data/rd_err are undefined while empty. Storage is not reset.
- Write-to-read latency is 1 cycle: wr_en at cycle N gives rd_valid=1 with the data at cycle N+1 (when empty at N).
- Pop at cycle N: next entry, or rd_valid=0, at N+1.
- count, full and empty reflect all pushes and pops one cycle later.
- Sustained 1 push + 1 pop per cycle is supported. The receiver produces at most one byte per bit-time × 10, so back-pressure only matters when the consumer stalls.
- Reset mid-operation empties the FIFO immediately, including any in-flight write.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8
  - typedef uart_rx_entry_t (struct: err, data)
- Sub-module uart_fifo_mem:
  - DEPTH × (DATA_W+1) register array
  - one synchronous write port
  - asynchronous read port
- Pointer, flag and overflow logic live in uart_rx_fifo.

## Test plan
- Reset, then single write of 0xA5 with wr_err=0 → next cycle rd_valid=1, rd_data=0xA5, rd_err=0, count=1. Pop → empty=1, count=0.
- Write 16 bytes 0x00..0x0F without reading → full=1, count=16. Drain → data in order 0x00..0x0F, empty=1 after the last pop.
- Full, then wr_en with 0xFF and rd_ready=0 → overflow=1, count=16, drained data still 0x00..0x0F. clr_overflow → overflow=0. Clear and drop in the same cycle → overflow stays 1.
- Full, then wr_en 0x55 with a pop in the same cycle → no overflow, count=16, 0x55 read last.
- Write 0x3C with wr_err=1, then 0x3D with wr_err=0 → rd_err=1 then 0 on respective pops. Run 40 random push/pop cycles to exercise pointer wrap, checking a scoreboard each cycle.
- Assert reset with 5 entries held → count=0, empty=1, rd_valid=0 immediately. A write after release is read back correctly.
